// File: rtl/adc_recepcion.sv
// Serial receiver for a 12-bit SPI-style ADC: drives CS/SCLK, shifts in one 16-bit frame MSB first
// and publishes the 12-bit sample on data_out with a one-cycle rx_done_tick strobe.
module adc_recepcion #(
   parameter int CLK_DIV = 4,
   parameter int N_BITS  = 16,
   parameter int QUIET   = 4
) (
   input  logic        clk_nexys,
   input  logic        reset,
   input  logic        ADCdata,
   input  logic        rx_en,
   output logic        rx_done_tick,
   output logic [15:0] b_reg,
   output logic [11:0] data_out,
   output logic        CS,
   output logic        SCLK
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(N_BITS + 1);
   localparam int QUI_W = (QUIET > 1) ? $clog2(QUIET) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_BITS - 1);
   localparam logic [QUI_W-1:0] QUI_LAST = QUI_W'(QUIET - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2,
      ST_QUIET = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [QUI_W-1:0]  q_cnt;
   logic              div_end;
   logic              rise_edge;
   logic              frame_end;
   logic              quiet_end;
   logic              cs_nxt;
   logic              tick_nxt;

   // A terminal divider count while SCLK is low means the coming toggle is a rising edge.
   assign div_end   = (div_cnt == DIV_LAST);
   assign rise_edge = div_end && !SCLK;
   assign frame_end = rise_edge && (bit_cnt == BIT_LAST);
   assign quiet_end = (q_cnt == QUI_LAST);

   // State register
   always_ff @(posedge clk_nexys) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (rx_en) begin
               state_nxt = ST_SHIFT;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (frame_end) begin
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_SHIFT;
            end
         end
         ST_DONE: begin
            state_nxt = ST_QUIET;
         end
         ST_QUIET: begin
            if (quiet_end) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_QUIET;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output decode on the next state so CS and the strobe are registered yet aligned to the state
   always_comb begin
      cs_nxt   = 1'b1;
      tick_nxt = 1'b0;
      case (state_nxt)
         ST_SHIFT: begin
            cs_nxt   = 1'b0;
            tick_nxt = 1'b0;
         end
         ST_DONE: begin
            cs_nxt   = 1'b1;
            tick_nxt = 1'b1;
         end
         default: begin
            cs_nxt   = 1'b1;
            tick_nxt = 1'b0;
         end
      endcase
   end

   // Datapath: serial clock generation, shift register, counters and output registers
   always_ff @(posedge clk_nexys) begin
      if (reset) begin
         CS           <= 1'b1;
         SCLK         <= 1'b1;
         rx_done_tick <= 1'b0;
         b_reg        <= 16'h0000;
         data_out     <= 12'h000;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         q_cnt        <= '0;
      end else begin
         CS           <= cs_nxt;
         rx_done_tick <= tick_nxt;
         case (state)
            ST_IDLE: begin
               SCLK    <= 1'b1;
               div_cnt <= '0;
               bit_cnt <= '0;
               q_cnt   <= '0;
               if (rx_en) begin
                  b_reg <= 16'h0000;
               end
            end
            ST_SHIFT: begin
               if (div_end) begin
                  div_cnt <= '0;
                  SCLK    <= ~SCLK;
                  // ADCdata was launched on the preceding falling edge; capture it on the rising one.
                  if (!SCLK) begin
                     b_reg   <= {b_reg[14:0], ADCdata};
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            ST_DONE: begin
               SCLK     <= 1'b1;
               q_cnt    <= '0;
               data_out <= b_reg[11:0];
            end
            ST_QUIET: begin
               SCLK  <= 1'b1;
               q_cnt <= q_cnt + QUI_W'(1);
            end
            default: begin
               SCLK <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_recepcion.sv
// Self-checking bench for adc_recepcion: behavioural ADC model, frame scoreboard and timing monitor.
module tb_adc_recepcion;

   logic        clk_nexys = 1'b0;
   logic        reset     = 1'b1;
   logic        ADCdata   = 1'b0;
   logic        rx_en     = 1'b0;
   logic        rx_done_tick;
   logic [15:0] b_reg;
   logic [11:0] data_out;
   logic        CS;
   logic        SCLK;

   int n_assert = 0;
   int n_fail   = 0;

   adc_recepcion dut (
      .clk_nexys    (clk_nexys),
      .reset        (reset),
      .ADCdata      (ADCdata),
      .rx_en        (rx_en),
      .rx_done_tick (rx_done_tick),
      .b_reg        (b_reg),
      .data_out     (data_out),
      .CS           (CS),
      .SCLK         (SCLK)
   );

   always #5 clk_nexys = ~clk_nexys;

   // ADC model: picks a word when CS falls, presents the next bit after every SCLK falling edge.
   logic [15:0] word_q[$];
   logic [15:0] sent_q[$];
   logic [15:0] cur_word = 16'h0000;
   int          bit_idx  = -1;

   always @(negedge CS) begin
      if (word_q.size() > 0) cur_word = word_q.pop_front();
      else                   cur_word = 16'($urandom);
      sent_q.push_back(cur_word);
      bit_idx = 15;
   end

   always @(negedge SCLK) begin
      if (!CS && bit_idx >= 0) begin
         ADCdata = cur_word[bit_idx];
         bit_idx = bit_idx - 1;
      end
   end

   // Monitor: CS-low window length, SCLK rising edges per window, SCLK period, idle levels.
   int   cyc = 0;
   logic prev_cs = 1'b1, prev_sclk = 1'b1;
   int   cur_len = 0, last_len = 0, cur_rises = 0, last_rises = 0;
   int   last_rise_cyc = -1, per_viol = 0, high_len = 0, last_high = 0;
   int   tick_total = 0, cs_low_total = 0, idle_sclk_viol = 0;

   always @(negedge clk_nexys) begin
      cyc = cyc + 1;
      if (reset) begin
         prev_cs = 1'b1; prev_sclk = 1'b1;
         cur_len = 0; cur_rises = 0; last_rise_cyc = -1;
      end else begin
         if (SCLK && !prev_sclk && !prev_cs) begin
            cur_rises = cur_rises + 1;
            if (last_rise_cyc >= 0 && (cyc - last_rise_cyc) != 8) per_viol = per_viol + 1;
            last_rise_cyc = cyc;
         end
         if (!CS) begin
            cur_len = cur_len + 1;
            cs_low_total = cs_low_total + 1;
            if (prev_cs) last_high = high_len;
            high_len = 0;
         end else begin
            high_len = high_len + 1;
            if (!prev_cs) begin
               last_len = cur_len; last_rises = cur_rises;
               cur_len = 0; cur_rises = 0; last_rise_cyc = -1;
            end
            if (!SCLK) idle_sclk_viol = idle_sclk_viol + 1;
         end
         if (rx_done_tick) tick_total = tick_total + 1;
         prev_cs = CS; prev_sclk = SCLK;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert = n_assert + 1;
      assert (obs === exp) else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_tick(input int max, output longint t, output logic ok);
      ok = 1'b0;
      t  = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk_nexys);
         if (rx_done_tick === 1'b1) begin
            ok = 1'b1;
            t  = longint'($time);
            break;
         end
      end
   endtask

   task automatic wait_cs_low(input int max, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk_nexys);
         if (CS === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pop_exp(output logic [15:0] w);
      if (sent_q.size() > 0) w = sent_q.pop_front();
      else                   w = 16'hxxxx;
   endtask

   // One completed frame: strobe seen, shift register and published sample match the model.
   task automatic check_frame(input string tag, output longint t);
      logic        ok;
      logic [15:0] e;
      wait_tick(300, t, ok);
      chk({tag, "_tick_seen"}, 32'(ok), 32'h1);
      pop_exp(e);
      chk({tag, "_b_reg"}, 32'(b_reg), 32'(e));
      @(negedge clk_nexys);
      chk({tag, "_data_out"}, 32'(data_out), 32'(e[11:0]));
      chk({tag, "_tick_width"}, 32'(rx_done_tick), 32'h0);
   endtask

   initial begin
      longint t0, t1, t2, tx;
      logic   ok;
      int     ticks0, lows0;

      reset = 1'b1;
      rx_en = 1'b1;
      word_q.push_back(16'h0ABC);
      word_q.push_back(16'h0FFF);
      word_q.push_back(16'h0000);
      for (int i = 0; i < 3; i++) word_q.push_back(16'($urandom));

      for (int i = 0; i < 5; i++) begin
         @(negedge clk_nexys);
         chk("rst_cs", 32'(CS), 32'h1);
         chk("rst_sclk", 32'(SCLK), 32'h1);
         chk("rst_data_out", 32'(data_out), 32'h0);
         chk("rst_tick", 32'(rx_done_tick), 32'h0);
      end
      reset = 1'b0;
      @(negedge clk_nexys);
      chk("cs_fall_after_reset", 32'(CS), 32'h0);

      check_frame("f0abc", t0);
      chk("f0abc_const_dout", 32'(data_out), 32'h0ABC);
      chk("cs_low_len", 32'(last_len), 32'd128);
      chk("sclk_rises", 32'(last_rises), 32'd16);

      check_frame("f0fff", t1);
      chk("f0fff_const_dout", 32'(data_out), 32'h0FFF);
      chk("period_1", 32'(t1 - t0), 32'd1340);

      check_frame("f0000", t2);
      chk("f0000_const_dout", 32'(data_out), 32'h0000);
      chk("period_2", 32'(t2 - t1), 32'd1340);
      chk("cs_high_gap", 32'(last_high >= 4), 32'h1);
      chk("cs_low_len_2", 32'(last_len), 32'd128);

      for (int i = 0; i < 3; i++) check_frame("rnd", tx);

      // Abort a frame with reset around bit 7, then receive a clean frame.
      wait_cs_low(300, ok);
      chk("abort_cs_low_seen", 32'(ok), 32'h1);
      repeat (52) @(negedge clk_nexys);
      reset = 1'b1;
      @(negedge clk_nexys);
      chk("abort_cs", 32'(CS), 32'h1);
      chk("abort_sclk", 32'(SCLK), 32'h1);
      chk("abort_b_reg", 32'(b_reg), 32'h0);
      chk("abort_data_out", 32'(data_out), 32'h0);
      sent_q.delete();
      word_q.delete();
      word_q.push_back(16'h0123);
      reset = 1'b0;
      check_frame("f0123", tx);
      chk("f0123_const_dout", 32'(data_out), 32'h0123);

      // Drop rx_en mid-frame: that frame completes, nothing follows.
      wait_cs_low(300, ok);
      chk("drop_cs_low_seen", 32'(ok), 32'h1);
      repeat (40) @(negedge clk_nexys);
      rx_en = 1'b0;
      check_frame("drop", tx);
      ticks0 = tick_total;
      lows0  = cs_low_total;
      repeat (300) @(negedge clk_nexys);
      chk("drop_no_tick", 32'(tick_total - ticks0), 32'h0);
      chk("drop_no_cs_low", 32'(cs_low_total - lows0), 32'h0);

      // rx_en low straight out of reset.
      reset = 1'b1;
      repeat (5) @(negedge clk_nexys);
      reset = 1'b0;
      ticks0 = tick_total;
      lows0  = cs_low_total;
      repeat (500) @(negedge clk_nexys);
      chk("idle_no_tick", 32'(tick_total - ticks0), 32'h0);
      chk("idle_no_cs_low", 32'(cs_low_total - lows0), 32'h0);
      chk("idle_cs", 32'(CS), 32'h1);
      chk("idle_sclk", 32'(SCLK), 32'h1);
      chk("sclk_period_8", 32'(per_viol), 32'h0);
      chk("sclk_high_when_cs_high", 32'(idle_sclk_viol), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
